// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-master round-robin arbiter for the byte-lane RAM port (optional stall counters: RAM_ARB_STALL_CNT_EN)
module ram_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_r,
  input  logic              m0_w,
  input  logic [1:0]        m0_sz,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_busy,
  output logic              m0_rvalid,
  input  logic              m1_r,
  input  logic              m1_w,
  input  logic [1:0]        m1_sz,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_busy,
  output logic              m1_rvalid,
  output logic [31:0]       m_rdata,
  output logic              ram_r,
  output logic              ram_w,
  output logic [1:0]        ram_sz,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
`ifdef RAM_ARB_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt0,
  output logic [31:0]       stall_cnt1
`endif
);

  localparam logic [1:0] OWN_NONE   = 2'd0;
  localparam logic [1:0] OWN_M0     = 2'd1;
  localparam logic [1:0] OWN_M1     = 2'd2;
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  logic [1:0] r_owner;
  logic       r_last;       // 0 = M0 granted most recently, 1 = M1
  logic [3:0] r_burst_cnt;
  logic       r_rvalid0;
  logic       r_rvalid1;

  logic [1:0] w_owner_nxt;
  logic       w_last_nxt;
  logic [3:0] w_burst_cnt_nxt;
  logic       w_req0;
  logic       w_req1;
  logic       w_gnt0;
  logic       w_gnt1;
  logic [1:0] w_gnt_own;

  // requests are masked while reset is held so nothing is granted in that cycle
  assign w_req0    = ~rst & (m0_r | m0_w);
  assign w_req1    = ~rst & (m1_r | m1_w);
  assign w_gnt_own = w_gnt1 ? OWN_M1 : OWN_M0;

  // grant: lone requester always wins; under contention the owner keeps the bus until its burst is spent
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_req0 && !w_req1) begin
      w_gnt0 = 1'b1;
    end else if (w_req1 && !w_req0) begin
      w_gnt1 = 1'b1;
    end else if (w_req0 && w_req1) begin
      if (r_owner == OWN_M0 && r_burst_cnt < BURST_LAST) begin
        w_gnt0 = 1'b1;
      end else if (r_owner == OWN_M1 && r_burst_cnt < BURST_LAST) begin
        w_gnt1 = 1'b1;
      end else if (r_last) begin
        w_gnt0 = 1'b1;
      end else begin
        w_gnt1 = 1'b1;
      end
    end
  end

  // next state: track bus owner, burst length and most recent winner
  always_comb begin
    w_owner_nxt     = r_owner;
    w_last_nxt      = r_last;
    w_burst_cnt_nxt = r_burst_cnt;
    if (w_gnt0 || w_gnt1) begin
      w_last_nxt = w_gnt1;
      if (r_owner == w_gnt_own) begin
        w_burst_cnt_nxt = (r_burst_cnt == BURST_LAST) ? r_burst_cnt : r_burst_cnt + 4'd1;
      end else begin
        w_owner_nxt     = w_gnt_own;
        w_burst_cnt_nxt = 4'd0;
      end
    end else begin
      w_owner_nxt     = OWN_NONE;
      w_burst_cnt_nxt = 4'd0;
    end
  end

  // outputs: busy flags and RAM port mux (idle port shows M0's fields for determinism)
  always_comb begin
    m0_busy   = w_req0 & ~w_gnt0;
    m1_busy   = w_req1 & ~w_gnt1;
    ram_w     = 1'b0;
    ram_r     = 1'b0;
    ram_sz    = m0_sz;
    ram_addr  = m0_addr;
    ram_wdata = m0_wdata;
    if (w_gnt0) begin
      ram_w = m0_w;
      ram_r = m0_r & ~m0_w;
    end else if (w_gnt1) begin
      ram_w     = m1_w;
      ram_r     = m1_r & ~m1_w;
      ram_sz    = m1_sz;
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
    end
  end

  // state register plus read-valid pipeline matching the RAM's one-cycle latency
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner     <= OWN_NONE;
      r_last      <= 1'b1;
      r_burst_cnt <= 4'd0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
    end else begin
      r_owner     <= w_owner_nxt;
      r_last      <= w_last_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_rvalid0   <= w_gnt0 & m0_r & ~m0_w;
      r_rvalid1   <= w_gnt1 & m1_r & ~m1_w;
    end
  end

  assign m0_rvalid = r_rvalid0 & ~rst;
  assign m1_rvalid = r_rvalid1 & ~rst;
  assign m_rdata   = ram_rdata;

`ifdef RAM_ARB_STALL_CNT_EN
  logic [31:0] r_stall_cnt0;
  logic [31:0] r_stall_cnt1;

  // per-master count of cycles spent waiting on the other master
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt0 <= 32'd0;
      r_stall_cnt1 <= 32'd0;
    end else begin
      if (m0_busy) r_stall_cnt0 <= r_stall_cnt0 + 32'd1;
      if (m1_busy) r_stall_cnt1 <= r_stall_cnt1 + 32'd1;
    end
  end

  assign stall_cnt0 = r_stall_cnt0;
  assign stall_cnt1 = r_stall_cnt1;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized self-checking bench for ram_arbiter against a behavioural model
module tb_ram_arbiter;
  localparam int AW = 32;
  localparam int MB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          m0_r, m0_w, m1_r, m1_w;
  logic [1:0]    m0_sz, m1_sz;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic          m0_busy, m1_busy, m0_rvalid, m1_rvalid;
  logic [31:0]   m_rdata;
  logic          ram_r, ram_w;
  logic [1:0]    ram_sz;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
`ifdef RAM_ARB_STALL_CNT_EN
  logic [31:0]   stall_cnt0, stall_cnt1;
`endif

  ram_arbiter #(.ADDR_W(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .m0_r(m0_r), .m0_w(m0_w), .m0_sz(m0_sz), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_busy(m0_busy), .m0_rvalid(m0_rvalid),
    .m1_r(m1_r), .m1_w(m1_w), .m1_sz(m1_sz), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_busy(m1_busy), .m1_rvalid(m1_rvalid),
    .m_rdata(m_rdata),
    .ram_r(ram_r), .ram_w(ram_w), .ram_sz(ram_sz), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef RAM_ARB_STALL_CNT_EN
    , .stall_cnt0(stall_cnt0), .stall_cnt1(stall_cnt1)
`endif
  );

  int checks = 0;
  int errors = 0;

  // reference model: owner (-1 none), length of its current run of grants, last winner
  int          mdl_owner;
  int          mdl_run;
  int          mdl_last;
  bit          mdl_rv0, mdl_rv1;
  logic [31:0] mdl_st0, mdl_st1;
  logic [31:0] exp_rdata;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_2468;
  endfunction

  function automatic int exp_grant();
    bit q0 = !rst && (m0_r || m0_w);
    bit q1 = !rst && (m1_r || m1_w);
    if (q0 && !q1) return 0;
    if (q1 && !q0) return 1;
    if (!q0 && !q1) return -1;
    if (mdl_owner >= 0 && mdl_run < MB) return mdl_owner;
    return 1 - mdl_last;
  endfunction

  task automatic idle_inputs();
    m0_r = 0; m0_w = 0; m1_r = 0; m1_w = 0;
    m0_sz = 2; m1_sz = 2;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
  endtask

  // advance one clock, updating the model and presenting RAM read data
  task automatic step();
    int g = exp_grant();
    bit q0 = !rst && (m0_r || m0_w);
    bit q1 = !rst && (m1_r || m1_w);
    bit rd = (g == 0) ? (m0_r && !m0_w) : (g == 1) ? (m1_r && !m1_w) : 1'b0;
    logic [31:0] ra = (g == 1) ? m1_addr : m0_addr;
    bit was_rst = rst;
    @(posedge clk);
    #1;
    if (was_rst) begin
      mdl_owner = -1; mdl_run = 0; mdl_last = 1; mdl_rv0 = 0; mdl_rv1 = 0;
      mdl_st0 = 0; mdl_st1 = 0;
    end else begin
      if (q0 && g != 0) mdl_st0 = mdl_st0 + 1;
      if (q1 && g != 1) mdl_st1 = mdl_st1 + 1;
      if (g >= 0) begin
        if (g == mdl_owner) mdl_run++;
        else begin mdl_owner = g; mdl_run = 1; end
        mdl_last = g;
      end else begin
        mdl_owner = -1; mdl_run = 0;
      end
      mdl_rv0 = rd && (g == 0);
      mdl_rv1 = rd && (g == 1);
    end
    exp_rdata = rd ? mem_word(ra) : $urandom();
    ram_rdata = exp_rdata;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs(); step(); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; m0_r = 1; m1_w = 1;
    #1;
    checks++; if (m0_busy !== 1'b0 || m1_busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy: got %b%b expected 00", m0_busy, m1_busy); end
    checks++; if (ram_r !== 1'b0 || ram_w !== 1'b0) begin errors++;
      $display("FAIL reset_strobes: got r=%b w=%b expected 0 0", ram_r, ram_w); end
    step();
    checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin errors++;
      $display("FAIL reset_rvalid: got %b%b expected 00", m0_rvalid, m1_rvalid); end
`ifdef RAM_ARB_STALL_CNT_EN
    checks++; if (stall_cnt0 !== 32'd0 || stall_cnt1 !== 32'd0) begin errors++;
      $display("FAIL reset_stall: got %0d %0d expected 0 0", stall_cnt0, stall_cnt1); end
`endif
    rst = 0; idle_inputs();
  endtask

  task automatic test_single_m0();
    idle_inputs(); step();
    m0_r = 1; m0_addr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (m0_busy !== 1'b0 || m1_busy !== 1'b0) begin errors++;
        $display("FAIL single_busy[%0d]: got %b%b expected 00", i, m0_busy, m1_busy); end
      checks++; if (ram_r !== 1'b1 || ram_addr !== 32'h10) begin errors++;
        $display("FAIL single_ram[%0d]: got r=%b addr=%h expected r=1 addr=10", i, ram_r, ram_addr); end
      step();
      checks++; if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m_rdata !== mem_word(32'h10)) begin errors++;
        $display("FAIL single_rdata[%0d]: got v0=%b v1=%b d=%h expected 1 0 %h", i, m0_rvalid, m1_rvalid, m_rdata, mem_word(32'h10)); end
    end
    idle_inputs(); step();
    checks++; if (m0_rvalid !== 1'b0) begin errors++;
      $display("FAIL single_tail: got %b expected 0", m0_rvalid); end
  endtask

  task automatic test_first_tie();
    do_reset();
    m0_w = 1; m0_addr = 32'h20; m0_wdata = 32'hDEADBEEF;
    m1_r = 1; m1_addr = 32'h24;
    #1;
    checks++; if (ram_w !== 1'b1 || ram_addr !== 32'h20 || ram_wdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL tie_m0: got w=%b addr=%h data=%h expected 1 20 deadbeef", ram_w, ram_addr, ram_wdata); end
    checks++; if (m0_busy !== 1'b0 || m1_busy !== 1'b1) begin errors++;
      $display("FAIL tie_busy: got %b%b expected 01", m0_busy, m1_busy); end
    step();
    m0_w = 0;
    #1;
    checks++; if (m1_busy !== 1'b0 || ram_r !== 1'b1 || ram_addr !== 32'h24) begin errors++;
      $display("FAIL tie_m1: got busy=%b r=%b addr=%h expected 0 1 24", m1_busy, ram_r, ram_addr); end
    step();
    m1_r = 0;
    checks++; if (m1_rvalid !== 1'b1 || m_rdata !== mem_word(32'h24)) begin errors++;
      $display("FAIL tie_rvalid: got v=%b d=%h expected 1 %h", m1_rvalid, m_rdata, mem_word(32'h24)); end
    idle_inputs(); step();
  endtask

  task automatic test_burst();
    do_reset();
    m0_r = 1; m0_addr = 32'h100; m1_r = 1; m1_addr = 32'h200;
    for (int k = 0; k < 4 * MB; k++) begin
      bit exp_m1 = ((k / MB) % 2) == 1;
      #1;
      checks++; if (m0_busy !== exp_m1 || m1_busy !== !exp_m1) begin errors++;
        $display("FAIL burst[%0d]: got busy %b%b expected %b%b", k, m0_busy, m1_busy, exp_m1, !exp_m1); end
      step();
`ifdef RAM_ARB_STALL_CNT_EN
      if (k == 2 * MB - 1) begin
        checks++; if (stall_cnt0 !== 32'd4 || stall_cnt1 !== 32'd4) begin errors++;
          $display("FAIL burst_stall: got %0d %0d expected 4 4", stall_cnt0, stall_cnt1); end
      end
`endif
    end
    rst = 1; step(); rst = 0;
`ifdef RAM_ARB_STALL_CNT_EN
    checks++; if (stall_cnt0 !== 32'd0 || stall_cnt1 !== 32'd0) begin errors++;
      $display("FAIL stall_clear: got %0d %0d expected 0 0", stall_cnt0, stall_cnt1); end
`endif
    idle_inputs(); step();
  endtask

  task automatic test_rw_both();
    idle_inputs(); step();
    m0_r = 1; m0_w = 1; m0_sz = 0; m0_addr = 32'h30; m0_wdata = 32'hAB;
    #1;
    checks++; if (ram_w !== 1'b1 || ram_r !== 1'b0 || ram_sz !== 2'd0 || ram_wdata !== 32'hAB) begin errors++;
      $display("FAIL rw_both: got w=%b r=%b sz=%0d d=%h expected 1 0 0 ab", ram_w, ram_r, ram_sz, ram_wdata); end
    step();
    idle_inputs();
    checks++; if (m0_rvalid !== 1'b0) begin errors++;
      $display("FAIL rw_rvalid: got %b expected 0", m0_rvalid); end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    m0_r = 1; m0_addr = 32'h40;
    step(); step();
    m0_r = 0; m1_r = 1; m1_addr = 32'h44; rst = 1;
    #1;
    checks++; if (m1_busy !== 1'b0 || ram_r !== 1'b0) begin errors++;
      $display("FAIL midrst_strobe: got busy=%b r=%b expected 0 0", m1_busy, ram_r); end
    step();
    rst = 0;
    checks++; if (m1_rvalid !== 1'b0) begin errors++;
      $display("FAIL midrst_rvalid: got %b expected 0", m1_rvalid); end
    m0_r = 1;
    #1;
    checks++; if (m0_busy !== 1'b0 || m1_busy !== 1'b1) begin errors++;
      $display("FAIL midrst_tie: got busy %b%b expected 01", m0_busy, m1_busy); end
    step();
    idle_inputs(); step();
  endtask

  task automatic test_random();
    bit pend0 = 0, pend1 = 0;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int  g;
      bit  q0, q1;
      rst = ($urandom_range(0, 39) == 0);
      if (!pend0) begin
        m0_r = $urandom_range(0, 1); m0_w = ($urandom_range(0, 3) == 0);
        m0_sz = 2'($urandom_range(0, 2)); m0_addr = $urandom(); m0_wdata = $urandom();
      end
      if (!pend1) begin
        m1_r = $urandom_range(0, 1); m1_w = ($urandom_range(0, 3) == 0);
        m1_sz = 2'($urandom_range(0, 2)); m1_addr = $urandom(); m1_wdata = $urandom();
      end
      #1;
      g  = exp_grant();
      q0 = !rst && (m0_r || m0_w);
      q1 = !rst && (m1_r || m1_w);
      checks++; if (m0_busy !== (q0 && g != 0) || m1_busy !== (q1 && g != 1)) begin errors++;
        $display("FAIL rnd_busy[%0d]: got %b%b expected %b%b", n, m0_busy, m1_busy, q0 && g != 0, q1 && g != 1); end
      checks++;
      if (ram_w !== ((g == 0) ? m0_w : (g == 1) ? m1_w : 1'b0) ||
          ram_r !== ((g == 0) ? (m0_r && !m0_w) : (g == 1) ? (m1_r && !m1_w) : 1'b0) ||
          ram_addr !== ((g == 1) ? m1_addr : m0_addr) ||
          ram_sz !== ((g == 1) ? m1_sz : m0_sz)) begin errors++;
        $display("FAIL rnd_ram[%0d]: got w=%b r=%b addr=%h sz=%0d, model grant %0d", n, ram_w, ram_r, ram_addr, ram_sz, g); end
      pend0 = q0 && g != 0;
      pend1 = q1 && g != 1;
      step();
      checks++; if (m0_rvalid !== (mdl_rv0 && !rst) || m1_rvalid !== (mdl_rv1 && !rst)) begin errors++;
        $display("FAIL rnd_rvalid[%0d]: got %b%b expected %b%b", n, m0_rvalid, m1_rvalid, mdl_rv0, mdl_rv1); end
      if (mdl_rv0 || mdl_rv1) begin
        checks++; if (m_rdata !== exp_rdata) begin errors++;
          $display("FAIL rnd_rdata[%0d]: got %h expected %h", n, m_rdata, exp_rdata); end
      end
`ifdef RAM_ARB_STALL_CNT_EN
      checks++; if (stall_cnt0 !== mdl_st0 || stall_cnt1 !== mdl_st1) begin errors++;
        $display("FAIL rnd_stall[%0d]: got %0d %0d expected %0d %0d", n, stall_cnt0, stall_cnt1, mdl_st0, mdl_st1); end
`endif
    end
    rst = 0; idle_inputs(); step();
  endtask

  initial begin
    rst = 1; idle_inputs(); ram_rdata = 0;
    mdl_owner = -1; mdl_run = 0; mdl_last = 1; mdl_rv0 = 0; mdl_rv1 = 0;
    mdl_st0 = 0; mdl_st1 = 0; exp_rdata = 0;
    #1;
    test_reset();
    test_single_m0();
    test_first_tie();
    test_burst();
    test_rw_both();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single byte-lane on-chip RAM port between two bus masters: M0 (core data/fetch port) and M1 (DMA/debug loader).
- Sits between the masters and the RAM write-strobe/read logic in top, replacing the direct core-to-RAM hookup.
- Drives each master's busy signal.
- Round-robin arbitration with a bounded burst hold, so neither master can starve the other.

Parameters:
- ADDR_W, 32, address width of master and RAM ports.
- MAX_BURST, 4, maximum consecutive accepted accesses by one master while the other is requesting (legal range 1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- m0_r / m1_r  in  1  read request; held until accepted
- m0_w / m1_w  in  1  write request; held until accepted
- m0_sz / m1_sz  in  2  access size: 0 byte, 1 half, 2 word
- m0_addr / m1_addr  in  ADDR_W  byte address
- m0_wdata / m1_wdata  in  32  write data
- m0_busy / m1_busy  out  1  request not accepted this cycle
- m0_rvalid / m1_rvalid  out  1  read data valid
- m_rdata  out  32  read data, broadcast to both masters
- ram_r  out  1  read strobe to RAM
- ram_w  out  1  write strobe to RAM
- ram_sz  out  2  size to RAM
- ram_addr  out  ADDR_W  address to RAM
- ram_wdata  out  32  write data to RAM
- ram_rdata  in  32  RAM read data, registered inside the RAM (1-cycle latency)

Behaviour:
- State registers:
  - owner: NONE/M0/M1
  - last: the master granted most recently
  - burst_cnt: 4 bits
  - rvalid0, rvalid1
- Reset values (synchronous, on rst high):
  - owner = NONE, last = M1 (so M0 wins the first tie), burst_cnt = 0, both rvalid = 0.
  - Outputs in the reset cycle: ram_r = ram_w = 0, both busy = 0, both rvalid = 0.
  - Request inputs are ignored while rst is high.
- Request definition: req_i = mi_r | mi_w.
- Grant (combinational, same cycle):
  - Only one master requests: that master is granted.
  - Both request, owner holds the bus and burst_cnt < MAX_BURST-1: the owner is granted.
  - Both request, otherwise: the master that is not `last` is granted.
- busy:
  - mi_busy = req_i & ~grant_i.
  - A request is accepted in a cycle where req_i is high and busy_i is low.
  - A request may be accepted in the same cycle it is first raised.
- RAM outputs:
  - Mux the granted master's sz/addr/wdata onto the RAM port.
  - ram_w = granted master's w; ram_r = granted master's r & ~w.
  - With no grant: ram_r = ram_w = 0; addr/sz/wdata are don't-care, but are driven from M0 for determinism.
- r and w both high from one master: treated as a write only; no rvalid follows.
- Read data:
  - rvalid_i is registered: rvalid_i <= grant_i & mi_r & ~mi_w.
  - m_rdata = ram_rdata (pass-through), valid exactly 1 cycle after acceptance.
  - The masters can be accepted back-to-back: one access per cycle, full throughput.
- Sequential update, on each cycle with a grant:
  - Same master as `owner`: burst_cnt <= burst_cnt + 1, saturating at MAX_BURST-1.
  - Different master: owner <= granted master, burst_cnt <= 0.
  - In both cases: last <= granted master.
- Sequential update, cycle with no request: owner <= NONE, burst_cnt <= 0.
- Burst counter and uncontended masters:
  - burst_cnt counts only while the owner keeps the grant.
  - A lone requester is never blocked; the burst limit applies only under contention.
- Reset mid-read: a read accepted in the cycle rst is asserted produces no rvalid.
- The RAM array itself is outside this block; write strobes are generated downstream from ram_sz and ram_addr[1:0].

Optional Feature:
- Macro: RAM_ARB_STALL_CNT_EN.
- When defined, adds output ports stall_cnt0 and stall_cnt1 (32 bits each):
  - stall_cnti increments every cycle mi_busy is high.
  - Wraps at 2^32.
  - Cleared by rst.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Only M0 reads addr 0x10 for 3 consecutive cycles → m1_busy = 0 throughout, m0_busy = 0 throughout; m0_rvalid high cycles 2..4 with m_rdata = RAM word at 0x10; m1_rvalid = 0.
- First cycle after reset, both masters request, M0 write 0xDEADBEEF to 0x20 and M1 read 0x24 → M0 granted (ram_w = 1, ram_addr = 0x20); m1_busy = 1; M1 granted next cycle; m1_rvalid the cycle after that.
- Both masters request continuously, MAX_BURST = 4 → grant sequence M0,M0,M0,M0,M1,M1,M1,M1,M0,…; each master's busy is high 4 cycles in every 8.
- M0 drives r = 1 and w = 1 to 0x30 with sz = 0, data 0xAB → ram_w = 1, ram_r = 0, m0_rvalid stays 0.
- rst asserted in the cycle an M1 read is accepted → next cycle m1_rvalid = 0, owner = NONE; the following tie is granted to M0.
- With RAM_ARB_STALL_CNT_EN defined and 8 cycles of continuous contention (MAX_BURST = 4) → stall_cnt0 = 4 and stall_cnt1 = 4; rst clears both to 0.
